// File: rtl/seg_hex595_scan.sv
// seg_hex595_scan: scanned hex 7-seg driver for a chained 74HC595 board.
// In: sys_clk, sys_rst_n, data, dp, blank_mask, lz_en.
// Out: clk/dat/str to the 595 chain, digit index, frame_done pulse.
module seg_hex595_scan #(
  parameter int DIGITS         = 8,
  parameter int CLK_DIV        = 4,
  parameter int HOLD_TICKS     = 256,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [4*DIGITS-1:0] data,
  input  logic [DIGITS-1:0]   dp,
  input  logic [DIGITS-1:0]   blank_mask,
  input  logic                lz_en,
  output logic                clk,
  output logic                dat,
  output logic                str,
  output logic [$clog2(DIGITS > 1 ? DIGITS : 2)-1:0] digit,
  output logic                frame_done
);

  localparam int W   = 8 + DIGITS;
  localparam int DGW = $clog2(DIGITS > 1 ? DIGITS : 2);
  localparam int DVW = $clog2(CLK_DIV > 1 ? CLK_DIV : 2);
  localparam int HCW = $clog2(HOLD_TICKS > 1 ? HOLD_TICKS : 2);
  localparam int BCW = $clog2(W);

  typedef enum logic [1:0] {
    LOAD,
    SHIFT,
    STROBE,
    HOLD
  } state_t;

  state_t           state;
  logic [DVW-1:0]   div_cnt;
  logic             tick;
  logic [W-1:0]     frame_q;
  logic [BCW-1:0]   bit_cnt;
  logic             phase;
  logic [HCW-1:0]   hold_cnt;

  logic [3:0]          nib;
  logic [4*DIGITS-1:0] hi_bits;
  logic                supp;
  logic [7:0]          seg_raw;
  logic [DIGITS-1:0]   sel_raw;
  logic [W-1:0]        frame_d;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    s = 7'h00;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  assign tick = (div_cnt == DVW'(CLK_DIV - 1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DVW'(1);
    end
  end

  // Leading zeros: digit and everything above it is zero.
  always_comb begin
    nib     = data[4*digit +: 4];
    hi_bits = data >> (4*digit);
    supp    = blank_mask[digit] ||
              (lz_en && (digit != '0) && (hi_bits == '0));
    seg_raw = supp ? 8'h00 : {dp[digit], hex7(nib)};
    sel_raw = DIGITS'(1) << digit;
    frame_d = {sel_raw ^ {DIGITS{SEL_ACTIVE_LOW}},
               seg_raw ^ {8{SEG_ACTIVE_LOW}}};
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= LOAD;
      frame_q    <= '0;
      bit_cnt    <= '0;
      phase      <= 1'b0;
      hold_cnt   <= '0;
      clk        <= 1'b0;
      dat        <= 1'b0;
      str        <= 1'b0;
      digit      <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (tick) begin
        unique case (state)
          LOAD: begin
            frame_q <= frame_d;
            bit_cnt <= '0;
            phase   <= 1'b0;
            state   <= SHIFT;
          end
          SHIFT: begin
            if (!phase) begin
              clk   <= 1'b0;
              dat   <= frame_q[W-1];
              phase <= 1'b1;
            end else begin
              clk     <= 1'b1;
              phase   <= 1'b0;
              frame_q <= frame_q << 1;
              bit_cnt <= bit_cnt + BCW'(1);
              if (bit_cnt == BCW'(W - 1)) begin
                state <= STROBE;
              end
            end
          end
          STROBE: begin
            clk      <= 1'b0;
            dat      <= 1'b0;
            str      <= 1'b1;
            hold_cnt <= '0;
            state    <= HOLD;
          end
          HOLD: begin
            clk <= 1'b0;
            dat <= 1'b0;
            str <= 1'b0;
            if (hold_cnt == HCW'(HOLD_TICKS - 1)) begin
              state <= LOAD;
              if (digit == DGW'(DIGITS - 1)) begin
                digit      <= '0;
                frame_done <= 1'b1;
              end else begin
                digit <= digit + DGW'(1);
              end
            end else begin
              hold_cnt <= hold_cnt + HCW'(1);
            end
          end
          default: state <= LOAD;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg_hex595_scan.sv
// Bench for seg_hex595_scan: three parameter sets against a
// timeline model plus a 595 shift/latch model.
module tb_seg_hex595_scan;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b1;
  bit   chk_on  = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  localparam int ND   [3] = '{8, 4, 1};
  localparam int CDIV [3] = '{4, 2, 1};
  localparam int HT   [3] = '{256, 3, 1};

  localparam logic [7:0] HEX [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  localparam logic [15:0] WANT0 [8] = '{
    16'hFEC0, 16'hFDF9, 16'hFBA4, 16'hF7B0,
    16'hEF99, 16'hDF92, 16'hBF82, 16'h7FF8};

  logic [31:0] data0 = 32'h7654_3210;
  logic [7:0]  dp0   = '0;
  logic [7:0]  bm0   = '0;
  logic        lz0   = 1'b0;
  logic [15:0] data1 = 16'h00A0;
  logic [3:0]  dp1   = 4'b0010;
  logic [3:0]  bm1   = '0;
  logic        lz1   = 1'b1;
  logic [3:0]  data2 = 4'h5;
  logic [0:0]  dp2   = 1'b1;
  logic [0:0]  bm2   = 1'b0;
  logic        lz2   = 1'b0;

  logic clk0, dat0, str0, fd0;
  logic clk1, dat1, str1, fd1;
  logic clk2, dat2, str2, fd2;
  logic [2:0] dig0;
  logic [1:0] dig1;
  logic [0:0] dig2;

  seg_hex595_scan u0 (
    .sys_clk(sys_clk), .sys_rst_n(rst_n),
    .data(data0), .dp(dp0), .blank_mask(bm0), .lz_en(lz0),
    .clk(clk0), .dat(dat0), .str(str0),
    .digit(dig0), .frame_done(fd0));

  seg_hex595_scan #(
    .DIGITS(4), .CLK_DIV(2), .HOLD_TICKS(3),
    .SEG_ACTIVE_LOW(1'b0), .SEL_ACTIVE_LOW(1'b0)
  ) u1 (
    .sys_clk(sys_clk), .sys_rst_n(rst_n),
    .data(data1), .dp(dp1), .blank_mask(bm1), .lz_en(lz1),
    .clk(clk1), .dat(dat1), .str(str1),
    .digit(dig1), .frame_done(fd1));

  seg_hex595_scan #(
    .DIGITS(1), .CLK_DIV(1), .HOLD_TICKS(1)
  ) u2 (
    .sys_clk(sys_clk), .sys_rst_n(rst_n),
    .data(data2), .dp(dp2), .blank_mask(bm2), .lz_en(lz2),
    .clk(clk2), .dat(dat2), .str(str2),
    .digit(dig2), .frame_done(fd2));

  // 595 chain: shift on clk rise, latch on str rise.
  logic [15:0] sr0 = '0;
  logic [11:0] sr1 = '0;
  logic [8:0]  sr2 = '0;
  logic [15:0] cap0 [$];
  logic [11:0] cap1 [$];
  logic [8:0]  cap2 [$];
  always @(posedge clk0) sr0 = {sr0[14:0], dat0};
  always @(posedge clk1) sr1 = {sr1[10:0], dat1};
  always @(posedge clk2) sr2 = {sr2[7:0], dat2};
  always @(posedge str0) cap0.push_back(sr0);
  always @(posedge str1) cap1.push_back(sr1);
  always @(posedge str2) cap2.push_back(sr2);

  function automatic int per(input int k);
    return 2 * (8 + ND[k]) + HT[k] + 2;
  endfunction

  function automatic logic [23:0] mk_frame(
    input int nd, input bit sal, input bit dal,
    input logic [63:0] d, input logic [15:0] p,
    input logic [15:0] b, input bit lz, input int i);
    logic [7:0]  seg;
    logic [15:0] sel;
    logic [3:0]  nib;
    logic [7:0]  h;
    nib = d[4*i +: 4];
    h   = HEX[nib];
    seg = {p[i], h[6:0]};
    if (b[i] || (lz && i > 0 && (d >> (4*i)) == 64'd0)) seg = 8'h00;
    sel = 16'd1 << i;
    if (sal) seg = ~seg;
    if (dal) sel = ~sel;
    sel = sel & ((16'd1 << nd) - 16'd1);
    return (24'(sel) << 8) | 24'(seg);
  endfunction

  function automatic logic [23:0] cur_frame(input int k, input int i);
    case (k)
      0: return mk_frame(8, 1, 1, 64'(data0), 16'(dp0), 16'(bm0), lz0, i);
      1: return mk_frame(4, 0, 0, 64'(data1), 16'(dp1), 16'(bm1), lz1, i);
      default:
        return mk_frame(1, 1, 1, 64'(data2), 16'(dp2), 16'(bm2), lz2, i);
    endcase
  endfunction

  // Timeline model: cycles since reset release and the frame
  // sampled at each digit's load tick.
  int cyc = 0;
  logic [23:0] frm [3];
  always @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0;
    end else begin
      cyc++;
      for (int k = 0; k < 3; k++) begin
        int n;
        if (cyc % CDIV[k] == 0) begin
          n = cyc / CDIV[k];
          if ((n - 1) % per(k) == 0)
            frm[k] = cur_frame(k, ((n - 1) / per(k)) % ND[k]);
        end
      end
    end
  end

  // e = {clk, dat, str, frame_done}
  function automatic void exp_at(input int k, input int c,
    output logic [3:0] e, output int ed, output bit dchk);
    int n, p, pr, w;
    w  = 8 + ND[k];
    pr = per(k);
    n  = c / CDIV[k];
    e  = '0;
    ed = 0;
    dchk = 1'b1;
    if (n > 0) begin
      p    = (n - 1) % pr;
      ed   = (n / pr) % ND[k];
      e[0] = (c % CDIV[k] == 0) && (n % (pr * ND[k]) == 0);
      if (p >= 1 && p <= 2 * w) begin
        e[3] = ((p - 1) % 2) == 1;
        e[2] = frm[k][w - 1 - (p - 1) / 2];
      end else if (p == 2 * w + 1) begin
        e[1] = 1'b1;
        dchk = 1'b0;
      end
    end
  endfunction

  int first_str0 = -1;
  int fd0_q [$];
  int fd1_q [$];
  int fd2_q [$];

  always @(negedge sys_clk) begin
    if (chk_on) begin
      for (int k = 0; k < 3; k++) begin
        logic [3:0] e, a;
        int ed, ad;
        bit dchk;
        exp_at(k, cyc, e, ed, dchk);
        case (k)
          0: begin a = {clk0, dat0, str0, fd0}; ad = int'(dig0); end
          1: begin a = {clk1, dat1, str1, fd1}; ad = int'(dig1); end
          default: begin a = {clk2, dat2, str2, fd2}; ad = int'(dig2); end
        endcase
        if (!dchk) begin
          a[2] = 1'b0;
          e[2] = 1'b0;
        end
        checks++;
        if (a !== e || ad != ed) begin
          errors++;
          $display("FAIL out%0d cyc=%0d clk/dat/str/fd=%b digit=%0d want %b digit=%0d",
                   k, cyc, a, ad, e, ed);
        end
      end
      if (str0 && first_str0 < 0) first_str0 = cyc;
      if (fd0) fd0_q.push_back(cyc);
      if (fd1) fd1_q.push_back(cyc);
      if (fd2) fd2_q.push_back(cyc);
    end
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  function automatic logic [31:0] q0(input int i);
    return (cap0.size() > i) ? 32'(cap0[i]) : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] q1(input int i);
    return (cap1.size() > i) ? 32'(cap1[i]) : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] q2(input int i);
    return (cap2.size() > i) ? 32'(cap2[i]) : 32'hFFFF_FFFF;
  endfunction
  function automatic int f0(input int i);
    return (fd0_q.size() > i) ? fd0_q[i] : -1;
  endfunction
  function automatic int f1(input int i);
    return (fd1_q.size() > i) ? fd1_q[i] : -1;
  endfunction
  function automatic int f2(input int i);
    return (fd2_q.size() > i) ? fd2_q[i] : -1;
  endfunction

  task automatic rnd0();
    data0 = $urandom >> (4 * $urandom_range(0, 8));
    dp0   = 8'($urandom);
    bm0   = 8'($urandom & $urandom & $urandom);
    lz0   = 1'($urandom);
  endtask

  task automatic seq0();
    int last;
    for (int t = 0; t < 12000 && fd0_q.size() < 1; t++) @(negedge sys_clk);
    chk("u0_scan_wait", 32'(fd0_q.size() >= 1), 1);
    chk("u0_first_str", first_str0, 136);
    for (int i = 0; i < 8; i++)
      chk($sformatf("u0_word%0d", i), q0(i), 32'(WANT0[i]));
    chk("u0_fd_first", f0(0), 9280);
    for (int t = 0; t < 400 && cyc < 9344; t++) @(negedge sys_clk);
    data0 = 32'hFEDC_BA98;
    for (int t = 0; t < 3000 && cap0.size() < 10; t++) @(negedge sys_clk);
    chk("u0_old_frame", q0(8), 32'h0000_FEC0);
    chk("u0_new_frame", q0(9), 32'h0000_FD90);
    for (int t = 0; t < 12000 && fd0_q.size() < 2; t++) begin
      @(negedge sys_clk);
      if ($urandom_range(0, 99) == 0) rnd0();
    end
    chk("u0_fd_period", f0(1) - f0(0), 9280);
    for (int t = 0; t < 8000 &&
         !(cyc > 18564 + 3 * 1160 && (cyc - 4) % 1160 == 61); t++)
      @(negedge sys_clk);
    chk("u0_pre_rst_digit", 32'(dig0), 3);
    data0 = 32'h0000_0C00;
    dp0 = '0;
    bm0 = '0;
    lz0 = 1'b1;
    @(posedge sys_clk);
    #1 rst_n = 1'b0;
    first_str0 = -1;
    #1 chk("u0_rst_async", {27'd0, clk0, dat0, str0, fd0, dig0}, 0);
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b1;
    for (int t = 0; t < 400 && first_str0 < 0; t++) @(negedge sys_clk);
    chk("u0_restart_str", first_str0, 136);
    last = cap0.size() - 1;
    chk("u0_restart_word", q0(last), 32'h0000_FEC0);
    for (int t = 0; t < 3000; t++) begin
      @(negedge sys_clk);
      if ($urandom_range(0, 99) == 0) rnd0();
    end
  endtask

  task automatic seq1();
    for (int t = 0; t < 1000 && cap1.size() < 4; t++) @(negedge sys_clk);
    chk("u1_dig0", q1(0), 32'h13F);
    chk("u1_dig1", q1(1), 32'h2F7);
    chk("u1_dig2", q1(2), 32'h400);
    chk("u1_dig3", q1(3), 32'h800);
    bm1 = 4'b0001;
    for (int t = 0; t < 1000 && cap1.size() < 5; t++) @(negedge sys_clk);
    chk("u1_blank0", q1(4), 32'h100);
    chk("u1_fd_first", f1(0), 232);
    for (int t = 0; t < 15000; t++) begin
      @(negedge sys_clk);
      if ($urandom_range(0, 39) == 0) begin
        data1 = 16'($urandom >> (4 * $urandom_range(0, 4)));
        dp1   = 4'($urandom);
        bm1   = 4'($urandom & $urandom);
        lz1   = 1'($urandom);
      end
    end
  endtask

  task automatic seq2();
    for (int t = 0; t < 300 && fd2_q.size() < 4; t++) @(negedge sys_clk);
    chk("u2_fd_first", f2(0), 21);
    for (int i = 1; i < 4; i++)
      chk($sformatf("u2_fd_gap%0d", i), f2(i) - f2(i - 1), 21);
    chk("u2_word", q2(0), 32'h012);
    chk("u2_digit", 32'(dig2), 0);
    for (int t = 0; t < 15000; t++) begin
      @(negedge sys_clk);
      if ($urandom_range(0, 19) == 0) begin
        data2 = 4'($urandom);
        dp2   = 1'($urandom);
        bm2   = 1'($urandom_range(0, 3) == 0);
        lz2   = 1'($urandom);
      end
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 chk_on = 1'b1;
    chk("rst_state0", {27'd0, clk0, dat0, str0, fd0, dig0}, 0);
    chk("rst_state1", {28'd0, clk1, dat1, str1, fd1}, 0);
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b1;
    fork
      seq0();
      seq1();
      seq2();
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog cyc=%0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
